word_tx_serializer: RTL
=======================

WORD_TX_SERIALIZER -- requirements
Module: word_tx_serializer

Interface
REQ-001 Parameter NBITS, default 32, width of the word accepted from the debug controller; SHALL be a multiple of 8.
REQ-002 Parameter BYTE_WIDTH, default 8, width of the byte handed to the UART transmitter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tx_start  input  1  one-cycle request from debug controller to send tx_Data.
REQ-006 tx_Data  input  NBITS  word to send; sampled only on an accepted tx_start.
REQ-007 byte_done  input  1  one-cycle pulse from UART transmitter: current byte fully shifted out.
REQ-008 byte_Data  output  BYTE_WIDTH  byte presented to UART transmitter.
REQ-009 byte_start  output  1  one-cycle pulse: UART transmitter shall load byte_Data.
REQ-010 tx_done  output  1  one-cycle pulse: whole word (plus checksum if enabled) sent.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, SEND, WAIT, DONE; registered; no other reachable states.
REQ-013 IDLE: tx_start=1 SHALL capture tx_Data into a shift register, clear byte index, go to SEND next edge.
REQ-014 SEND: byte_start=1 for exactly this cycle, byte_Data = byte[index]; next state WAIT.
REQ-015 Byte order SHALL be LSB first: byte 0 = tx_Data[7:0], byte NBITS/8-1 = top byte.
REQ-016 byte_Data SHALL hold its value from SEND through WAIT until the next SEND.
REQ-017 WAIT: on byte_done, if more bytes remain, index increments and next state SEND; else next state DONE.
REQ-018 DONE: tx_done=1 for exactly this cycle; next state IDLE.
REQ-019 Latency: tx_start in cycle N -> first byte_start in N+1; byte_done in cycle M -> next byte_start in M+1; last byte_done in M -> tx_done in M+1.
REQ-020 tx_start outside IDLE SHALL be ignored; the in-flight word and tx_Data register are unchanged.
REQ-021 byte_done outside WAIT SHALL be ignored.
REQ-022 byte_done and tx_start in the same cycle: only the one relevant to the current state takes effect.
REQ-023 Index SHALL not wrap; reaching the last byte always exits to DONE.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, byte_Data=0, byte_start=0, tx_done=0, busy=0, index=0, shift register=0.
REQ-025 rst mid-transfer SHALL abort silently: no tx_done, no further byte_start.
REQ-026 rst has priority over tx_start and byte_done in the same cycle.

Configuration
REQ-027 Macro WORD_TX_CHECKSUM_EN, when defined, SHALL append one extra byte after the last data byte: XOR of all NBITS/8 data bytes, via a SEND/WAIT pair identical to data bytes; tx_done follows its byte_done.
REQ-028 Without WORD_TX_CHECKSUM_EN, exactly NBITS/8 bytes SHALL be sent and no checksum logic SHALL exist.

Structure
REQ-029 State encoding, BYTE_WIDTH and the bytes-per-word constant (NBITS/8) SHALL live in the shared debug package.
REQ-030 Single module; no sub-module is natural (shift register, index counter and checksum accumulator are inline).

Verification
REQ-031 tx_Data=0xDEADBEEF, tx_start 1 cycle, byte_done 5 cycles after each byte_start -> byte_Data sequence EF, BE, AD, DE; tx_done 1 cycle after fourth byte_done.
REQ-032 tx_start pulsed while busy with tx_Data=0x12345678 during 0xDEADBEEF transfer -> sequence still EF, BE, AD, DE; no extra transfer.
REQ-033 rst asserted after second byte_done -> busy=0 next cycle, no tx_done, no further byte_start; a new tx_start of 0x00000001 sends 01,00,00,00.
REQ-034 byte_done pulse in IDLE and in SEND -> no state change, no byte skipped.
REQ-035 WORD_TX_CHECKSUM_EN defined, tx_Data=0xDEADBEEF -> bytes EF, BE, AD, DE, 22; tx_done after fifth byte_done.
REQ-036 Back-to-back: tx_start in the cycle after tx_done -> accepted, first byte_start next cycle.

Source files
------------

// File: rtl/word_tx_serializer_pkg.sv
// Shared debug package: FSM state encoding and sizing constants
// used by the word-to-byte serializer feeding the UART transmitter.
package word_tx_serializer_pkg;

   localparam int DBG_BYTE_WIDTH     = 8;
   localparam int DBG_NBITS          = 32;
   localparam int DBG_BYTES_PER_WORD = DBG_NBITS / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } tx_state_e;

   function automatic int bytes_per_word(input int nbits);
      return nbits / 8;
   endfunction

endpackage

// File: rtl/word_tx_serializer.sv
// Splits an NBITS word into bytes (LSB first) for a UART transmitter.
// Define WORD_TX_CHECKSUM_EN to append an XOR checksum byte.
module word_tx_serializer
   import word_tx_serializer_pkg::*;
#(
   parameter int NBITS      = DBG_NBITS,
   parameter int BYTE_WIDTH = DBG_BYTE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_start,
   input  logic [NBITS-1:0]      tx_Data,
   input  logic                  byte_done,
   output logic [BYTE_WIDTH-1:0] byte_Data,
   output logic                  byte_start,
   output logic                  tx_done,
   output logic                  busy
);

   localparam int NBYTES = bytes_per_word(NBITS);
`ifdef WORD_TX_CHECKSUM_EN
   localparam int TOTAL  = NBYTES + 1;
`else
   localparam int TOTAL  = NBYTES;
`endif
   localparam int IW     = $clog2(TOTAL + 1);

   tx_state_e             r_state;
   tx_state_e             w_next;
   logic [NBITS-1:0]      r_shift;
   logic [IW-1:0]         r_idx;
   logic [BYTE_WIDTH-1:0] r_byte;
   logic [IW-1:0]         w_nidx;
   logic [BYTE_WIDTH-1:0] w_data_byte;
   logic [BYTE_WIDTH-1:0] w_nbyte;
   logic                  w_last;
   logic                  w_load;
   logic                  w_adv;

   assign w_last = (r_idx == IW'(TOTAL - 1));
   assign w_load = (r_state == ST_IDLE) && tx_start;
   assign w_adv  = (r_state == ST_WAIT) && byte_done && !w_last;
   assign w_nidx = r_idx + IW'(1);

   // Past the last data byte the shift yields zero
   assign w_data_byte =
      BYTE_WIDTH'(r_shift >> (BYTE_WIDTH * int'(w_nidx)));

`ifdef WORD_TX_CHECKSUM_EN
   logic [BYTE_WIDTH-1:0] r_csum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_csum <= '0;
      end else if (w_load) begin
         r_csum <= tx_Data[BYTE_WIDTH-1:0];
      end else if (w_adv) begin
         r_csum <= r_csum ^ w_data_byte;
      end
   end

   assign w_nbyte = (w_nidx == IW'(NBYTES)) ? r_csum : w_data_byte;
`else
   assign w_nbyte = w_data_byte;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (tx_start)  w_next = ST_SEND;
         ST_SEND:                w_next = ST_WAIT;
         ST_WAIT: if (byte_done) w_next = w_last ? ST_DONE : ST_SEND;
         ST_DONE:                w_next = ST_IDLE;
         default:                w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_start = 1'b0;
      tx_done    = 1'b0;
      busy       = 1'b1;
      case (r_state)
         ST_IDLE: busy       = 1'b0;
         ST_SEND: byte_start = 1'b1;
         ST_DONE: tx_done    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_byte  <= '0;
      end else if (w_load) begin
         r_shift <= tx_Data;
         r_idx   <= '0;
         r_byte  <= tx_Data[BYTE_WIDTH-1:0];
      end else if (w_adv) begin
         r_idx   <= w_nidx;
         r_byte  <= w_nbyte;
      end
   end

   assign byte_Data = r_byte;

endmodule
